// File: rtl/display_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
// Shared definitions for the display front end: VGA raster constants, the
// frame-sync FSM state encoding, shadow-field widths and the packed snapshot
// record that carries one complete game state from game logic to the display.
// -----------------------------------------------------------------------------
package display_pkg;

   // Raster geometry of the 640x480 VGA mode driving h_cnt / v_cnt
   localparam int H_VISIBLE = 640;
   localparam int V_VISIBLE = 480;
   localparam int V_TOTAL   = 525;

   // Widths of the raster counters and the shadowed game fields
   localparam int CNT_W   = 10;
   localparam int STATE_W = 4;
   localparam int POS_W   = 9;
   localparam int HUD_W   = 2;
   localparam int MASK_W  = 4;

   // Widths of the frame-timing outputs
   localparam int FRAME_CNT_W = 16;
   localparam int SHIFT_W     = 6;
   localparam int STALL_W     = 8;

   // Frame-sync sequencer states
   typedef enum logic [1:0] {
      S_ACTIVE = 2'd0,
      S_BLANK  = 2'd1,
      S_HOLD   = 2'd2
   } sync_state_t;

   // One complete game-state snapshot as seen by the display path
   typedef struct packed {
      logic [STATE_W-1:0] state;
      logic [STATE_W-1:0] player_state;
      logic [STATE_W-1:0] boss_state;
      logic [POS_W-1:0]   player_x;
      logic [POS_W-1:0]   player_y;
      logic [POS_W-1:0]   boss_x;
      logic [POS_W-1:0]   boss_y;
      logic [POS_W-1:0]   obj_x;
      logic [POS_W-1:0]   obj_y;
      logic [HUD_W-1:0]   key_find;
      logic [HUD_W-1:0]   life;
      logic [HUD_W-1:0]   todo;
      logic [MASK_W-1:0]  play_valid;
   } snapshot_t;

   // True on the first pixel of the first blanking line
   function automatic logic is_boundary(input logic [CNT_W-1:0] h,
                                        input logic [CNT_W-1:0] v,
                                        input logic [CNT_W-1:0] v_vis);
      return (v == v_vis) && (h == '0);
   endfunction

endpackage

// File: rtl/dark_timer.sv
// -----------------------------------------------------------------------------
// dark_timer
// Frame-based flash timer. A trigger (re)loads the counter with DARK_FRAMES and
// raises dark_active on the next clock; every frame_start pulse counts it down
// and dark_active drops when it reaches zero. A trigger that lands on the same
// clock as frame_start reloads rather than decrements.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-low reset
//   frame_start  one-cycle frame boundary pulse
//   dark_trig    one-cycle flash request
//   dark_active  flash in progress (registered)
// -----------------------------------------------------------------------------
module dark_timer #(
   parameter int DARK_FRAMES = 30
) (
   input  logic clk,
   input  logic rst,
   input  logic frame_start,
   input  logic dark_trig,
   output logic dark_active
);

   localparam int CW = (DARK_FRAMES > 1) ? $clog2(DARK_FRAMES + 1) : 1;

   logic [CW-1:0] frames_left;

   // Reload has priority over the frame decrement so a retrigger always
   // restarts a full-length flash, even on a frame boundary. The flag is
   // cleared on the same edge that takes the count from one to zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         frames_left <= '0;
         dark_active <= 1'b0;
      end else if (dark_trig) begin
         frames_left <= CW'(DARK_FRAMES);
         dark_active <= 1'b1;
      end else if (frame_start && (frames_left != '0)) begin
         frames_left <= frames_left - 1'b1;
         if (frames_left == CW'(1)) begin
            dark_active <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/frame_sync_ctrl.sv
// -----------------------------------------------------------------------------
// frame_sync_ctrl
// Frame-level sequencer in front of the display layer mux. Game-logic values
// are copied into shadow registers only during vertical blanking (at most one
// snapshot per frame), so a rendered frame never mixes two game states. The
// block also produces per-frame timing: frame_start pulse, frame counter,
// interface scroll offset (shift) and the timed dark flash (isDark).
//
// Optional build macro:
//   FRAME_SYNC_STALL_CNT_EN  adds stall_cnt, a saturating count of frames that
//                            ended blanking without a new snapshot; cleared by
//                            the next accepted snapshot.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   h_cnt, v_cnt             VGA raster counters (may hold for several clocks)
//   upd_valid / upd_ready    snapshot handshake with the game logic
//   in_*                     live game state, positions and HUD values
//   dark_trig                one-cycle dark flash request
//   state ... play_valid     shadowed copies of in_*
//   frame_start              one-cycle pulse per frame boundary
//   frame_cnt                frames since reset (wraps)
//   shift                    scroll offset, advances every SHIFT_DIV frames
//   stall_cnt                stale-frame count (FRAME_SYNC_STALL_CNT_EN only)
//   isDark                   dark flash active
// -----------------------------------------------------------------------------
module frame_sync_ctrl #(
   parameter int V_VISIBLE   = display_pkg::V_VISIBLE,
   parameter int SHIFT_DIV   = 4,
   parameter int SHIFT_MAX   = 63,
   parameter int DARK_FRAMES = 30
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [9:0]  h_cnt,
   input  logic [9:0]  v_cnt,
   input  logic        upd_valid,
   output logic        upd_ready,
   input  logic [3:0]  in_state,
   input  logic [3:0]  in_player_state,
   input  logic [3:0]  in_boss_state,
   input  logic [8:0]  in_player_x,
   input  logic [8:0]  in_player_y,
   input  logic [8:0]  in_boss_x,
   input  logic [8:0]  in_boss_y,
   input  logic [8:0]  in_obj_x,
   input  logic [8:0]  in_obj_y,
   input  logic [1:0]  in_key_find,
   input  logic [1:0]  in_life,
   input  logic [1:0]  in_todo,
   input  logic [3:0]  in_play_valid,
   input  logic        dark_trig,
   output logic [3:0]  state,
   output logic [3:0]  player_state,
   output logic [3:0]  boss_state,
   output logic [8:0]  player_x,
   output logic [8:0]  player_y,
   output logic [8:0]  boss_x,
   output logic [8:0]  boss_y,
   output logic [8:0]  obj_x,
   output logic [8:0]  obj_y,
   output logic [1:0]  key_find,
   output logic [1:0]  life,
   output logic [1:0]  todo,
   output logic [3:0]  play_valid,
   output logic        frame_start,
   output logic [15:0] frame_cnt,
   output logic [5:0]  shift,
`ifdef FRAME_SYNC_STALL_CNT_EN
   output logic [7:0]  stall_cnt,
`endif
   output logic        isDark
);

   import display_pkg::sync_state_t;
   import display_pkg::snapshot_t;
   import display_pkg::S_ACTIVE;
   import display_pkg::S_BLANK;
   import display_pkg::S_HOLD;
   import display_pkg::is_boundary;

   localparam int DIV_W = (SHIFT_DIV > 1) ? $clog2(SHIFT_DIV) : 1;

   sync_state_t      fsm_q;
   snapshot_t        in_snap;
   snapshot_t        shadow_q;
   logic             boundary;
   logic             boundary_q;
   logic             new_frame;
   logic             handshake;
   logic [DIV_W-1:0] shift_div_q;

   // Gather the live game inputs into one record so they are captured together
   always_comb begin
      in_snap              = '0;
      in_snap.state        = in_state;
      in_snap.player_state = in_player_state;
      in_snap.boss_state   = in_boss_state;
      in_snap.player_x     = in_player_x;
      in_snap.player_y     = in_player_y;
      in_snap.boss_x       = in_boss_x;
      in_snap.boss_y       = in_boss_y;
      in_snap.obj_x        = in_obj_x;
      in_snap.obj_y        = in_obj_y;
      in_snap.key_find     = in_key_find;
      in_snap.life         = in_life;
      in_snap.todo         = in_todo;
      in_snap.play_valid   = in_play_valid;
   end

   assign boundary  = is_boundary(h_cnt, v_cnt, 10'(V_VISIBLE));
   assign new_frame = (v_cnt < 10'(V_VISIBLE));
   assign handshake = upd_valid && upd_ready;

   // The raster counters can sit on the boundary pixel for several clocks when
   // clk runs faster than the pixel clock, so only the rising edge of the
   // boundary condition produces a frame_start pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         boundary_q  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         boundary_q  <= boundary;
         frame_start <= boundary && !boundary_q;
      end
   end

   // Snapshot sequencer. upd_ready is a registered function of the state only,
   // so a producer that holds upd_valid high is accepted on the first blanking
   // cycle. A capture moves to S_HOLD, which keeps ready low for the rest of
   // the blanking interval so only one snapshot lands per frame. Leaving
   // S_BLANK when the next frame starts without a handshake keeps the old
   // shadows for another frame.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fsm_q     <= S_ACTIVE;
         upd_ready <= 1'b0;
         shadow_q  <= '0;
      end else begin
         unique case (fsm_q)
            S_ACTIVE: begin
               if (frame_start) begin
                  fsm_q     <= S_BLANK;
                  upd_ready <= 1'b1;
               end
            end
            S_BLANK: begin
               if (handshake) begin
                  shadow_q  <= in_snap;
                  fsm_q     <= S_HOLD;
                  upd_ready <= 1'b0;
               end else if (new_frame) begin
                  fsm_q     <= S_ACTIVE;
                  upd_ready <= 1'b0;
               end
            end
            S_HOLD: begin
               if (new_frame) begin
                  fsm_q <= S_ACTIVE;
               end
            end
            default: begin
               fsm_q     <= S_ACTIVE;
               upd_ready <= 1'b0;
            end
         endcase
      end
   end

   // Frame counter and scroll offset. The divider steps once per frame and
   // advances shift on its terminal count; shift wraps after SHIFT_MAX.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         frame_cnt   <= '0;
         shift_div_q <= '0;
         shift       <= '0;
      end else if (frame_start) begin
         frame_cnt <= frame_cnt + 16'd1;
         if (shift_div_q == DIV_W'(SHIFT_DIV - 1)) begin
            shift_div_q <= '0;
            if (shift == 6'(SHIFT_MAX)) begin
               shift <= '0;
            end else begin
               shift <= shift + 6'd1;
            end
         end else begin
            shift_div_q <= shift_div_q + 1'b1;
         end
      end
   end

`ifdef FRAME_SYNC_STALL_CNT_EN
   // Counts frames that start rendering with stale state: blanking ended with
   // no snapshot taken. Saturates so a long stall stays visible; any accepted
   // snapshot clears it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt <= '0;
      end else if ((fsm_q == S_BLANK) && handshake) begin
         stall_cnt <= '0;
      end else if ((fsm_q == S_BLANK) && new_frame && (stall_cnt != 8'hFF)) begin
         stall_cnt <= stall_cnt + 8'd1;
      end
   end
`endif

   dark_timer #(
      .DARK_FRAMES (DARK_FRAMES)
   ) u_dark_timer (
      .clk         (clk),
      .rst         (rst),
      .frame_start (frame_start),
      .dark_trig   (dark_trig),
      .dark_active (isDark)
   );

   assign state        = shadow_q.state;
   assign player_state = shadow_q.player_state;
   assign boss_state   = shadow_q.boss_state;
   assign player_x     = shadow_q.player_x;
   assign player_y     = shadow_q.player_y;
   assign boss_x       = shadow_q.boss_x;
   assign boss_y       = shadow_q.boss_y;
   assign obj_x        = shadow_q.obj_x;
   assign obj_y        = shadow_q.obj_y;
   assign key_find     = shadow_q.key_find;
   assign life         = shadow_q.life;
   assign todo         = shadow_q.todo;
   assign play_valid   = shadow_q.play_valid;

endmodule

// File: tb/tb_frame_sync_ctrl.sv
// -----------------------------------------------------------------------------
// tb_frame_sync_ctrl
// Self-checking bench for frame_sync_ctrl. Raster counters are driven directly
// (boundary pixel, a few blanking clocks, then line 0) so frames are short.
// Accepted snapshots go through a scoreboard queue; frame timing is checked
// against a small reference model. Build with FRAME_SYNC_STALL_CNT_EN to also
// cover stall_cnt.
// -----------------------------------------------------------------------------
module tb_frame_sync_ctrl;

   localparam int TB_DARK  = 3;
   localparam int TB_DIV   = 4;
   localparam int TB_SMAX  = 63;

   logic        clk = 1'b0;
   logic        rst;
   logic [9:0]  h_cnt, v_cnt;
   logic        upd_valid, upd_ready;
   logic [3:0]  in_state, in_player_state, in_boss_state, in_play_valid;
   logic [8:0]  in_player_x, in_player_y, in_boss_x, in_boss_y, in_obj_x, in_obj_y;
   logic [1:0]  in_key_find, in_life, in_todo;
   logic        dark_trig;
   logic [3:0]  state, player_state, boss_state, play_valid;
   logic [8:0]  player_x, player_y, boss_x, boss_y, obj_x, obj_y;
   logic [1:0]  key_find, life, todo;
   logic        frame_start;
   logic [15:0] frame_cnt;
   logic [5:0]  shift;
   logic        isDark;
`ifdef FRAME_SYNC_STALL_CNT_EN
   logic [7:0]  stall_cnt;
`endif

   int check_cnt = 0;
   int pass_cnt  = 0;

   // Scoreboard of snapshots offered to the DUT, popped when one is accepted
   logic [75:0] exp_q[$];
   logic [75:0] last_snap;
   logic [75:0] exp_snap;

   // Reference model of frame timing
   int exp_frames, exp_div, exp_shift, exp_stall;

   always #5 clk = ~clk;

   frame_sync_ctrl #(
      .V_VISIBLE   (480),
      .SHIFT_DIV   (TB_DIV),
      .SHIFT_MAX   (TB_SMAX),
      .DARK_FRAMES (TB_DARK)
   ) dut (
      .clk (clk), .rst (rst), .h_cnt (h_cnt), .v_cnt (v_cnt),
      .upd_valid (upd_valid), .upd_ready (upd_ready),
      .in_state (in_state), .in_player_state (in_player_state),
      .in_boss_state (in_boss_state), .in_player_x (in_player_x),
      .in_player_y (in_player_y), .in_boss_x (in_boss_x), .in_boss_y (in_boss_y),
      .in_obj_x (in_obj_x), .in_obj_y (in_obj_y), .in_key_find (in_key_find),
      .in_life (in_life), .in_todo (in_todo), .in_play_valid (in_play_valid),
      .dark_trig (dark_trig),
      .state (state), .player_state (player_state), .boss_state (boss_state),
      .player_x (player_x), .player_y (player_y), .boss_x (boss_x),
      .boss_y (boss_y), .obj_x (obj_x), .obj_y (obj_y), .key_find (key_find),
      .life (life), .todo (todo), .play_valid (play_valid),
      .frame_start (frame_start), .frame_cnt (frame_cnt), .shift (shift),
`ifdef FRAME_SYNC_STALL_CNT_EN
      .stall_cnt (stall_cnt),
`endif
      .isDark (isDark)
   );

   function automatic logic [75:0] in_snap();
      return {in_state, in_player_state, in_boss_state, in_player_x, in_player_y,
              in_boss_x, in_boss_y, in_obj_x, in_obj_y, in_key_find, in_life,
              in_todo, in_play_valid};
   endfunction

   function automatic logic [75:0] dut_snap();
      return {state, player_state, boss_state, player_x, player_y, boss_x,
              boss_y, obj_x, obj_y, key_find, life, todo, play_valid};
   endfunction

   function automatic logic [100:0] all_outs();
      return {dut_snap(), upd_ready, frame_start, frame_cnt, shift, isDark};
   endfunction

   task automatic set_inputs(input int seed);
      in_state        = 4'(seed);
      in_player_state = 4'(seed + 1);
      in_boss_state   = 4'(seed + 2);
      in_player_x     = 9'(seed * 7 + 3);
      in_player_y     = 9'(seed * 5 + 11);
      in_boss_x       = 9'(seed * 3 + 29);
      in_boss_y       = 9'(seed + 200);
      in_obj_x        = 9'(seed * 11 + 1);
      in_obj_y        = 9'(seed * 13 + 2);
      in_key_find     = 2'(seed);
      in_life         = 2'(seed + 1);
      in_todo         = 2'(seed + 3);
      in_play_valid   = 4'(seed ^ 5);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic model_reset();
      exp_frames = 0;
      exp_div    = 0;
      exp_shift  = 0;
      exp_stall  = 0;
      last_snap  = '0;
      exp_q.delete();
   endtask

   task automatic model_frame();
      exp_frames = (exp_frames + 1) % 65536;
      if (exp_div == TB_DIV - 1) begin
         exp_div   = 0;
         exp_shift = (exp_shift == TB_SMAX) ? 0 : exp_shift + 1;
      end else begin
         exp_div = exp_div + 1;
      end
   endtask

   // Park on the boundary pixel for one clock; frame_start is visible after it
   task automatic frame_edge();
      v_cnt = 10'd480;
      h_cnt = 10'd0;
      cyc(1);
      model_frame();
   endtask

   task automatic end_frame();
      v_cnt = 10'd0;
      h_cnt = 10'd0;
      cyc(2);
   endtask

   // Short frame with one blanking clock; stale if no upd_valid
   task automatic fast_frame();
      frame_edge();
      h_cnt = 10'd1;
      cyc(1);
      end_frame();
      if (!upd_valid && exp_stall < 255) exp_stall = exp_stall + 1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      cyc(1);
      check_cnt++;
      if (all_outs() !== '0) $display("[TB] FAIL reset_outputs: got %h want 0", all_outs());
      else pass_cnt++;
`ifdef FRAME_SYNC_STALL_CNT_EN
      check_cnt++;
      if (stall_cnt !== 8'd0) $display("[TB] FAIL reset_stall: got %0d want 0", stall_cnt);
      else pass_cnt++;
`endif
      rst = 1'b1;
      model_reset();
      cyc(2);
      check_cnt++;
      if (all_outs() !== '0) $display("[TB] FAIL post_reset_idle: got %h want 0", all_outs());
      else pass_cnt++;
   endtask

   task automatic test_handshake();
      set_inputs(1);
      in_player_x = 9'd100;
      upd_valid   = 1'b1;
      exp_q.push_back(in_snap());
      frame_edge();
      check_cnt++;
      if (frame_start !== 1'b1) $display("[TB] FAIL hs_frame_start: got %0b want 1", frame_start);
      else pass_cnt++;
      check_cnt++;
      if (upd_ready !== 1'b0) $display("[TB] FAIL hs_ready_early: got %0b want 0", upd_ready);
      else pass_cnt++;
      h_cnt = 10'd1;
      cyc(1);
      check_cnt++;
      if (upd_ready !== 1'b1 || frame_start !== 1'b0)
         $display("[TB] FAIL hs_ready_rise: got ready=%0b fs=%0b want ready=1 fs=0", upd_ready, frame_start);
      else pass_cnt++;
      check_cnt++;
      if (dut_snap() !== last_snap) $display("[TB] FAIL hs_no_early_latch: got %h want %h", dut_snap(), last_snap);
      else pass_cnt++;
      cyc(1);
      exp_snap = exp_q.pop_front();
      check_cnt++;
      if (dut_snap() !== exp_snap || player_x !== 9'd100)
         $display("[TB] FAIL hs_snapshot: got %h want %h", dut_snap(), exp_snap);
      else pass_cnt++;
      last_snap = exp_snap;
      exp_stall = 0;
      // Still blanking with valid held: a second offer must wait a frame
      in_player_x = 9'd200;
      exp_q.push_back(in_snap());
      cyc(2);
      check_cnt++;
      if (upd_ready !== 1'b0 || player_x !== 9'd100)
         $display("[TB] FAIL hold_blocks: got ready=%0b x=%0d want ready=0 x=100", upd_ready, player_x);
      else pass_cnt++;
      end_frame();
      check_cnt++;
      if (player_x !== 9'd100) $display("[TB] FAIL hold_active_x: got %0d want 100", player_x);
      else pass_cnt++;
      frame_edge();
      h_cnt = 10'd1;
      cyc(2);
      exp_snap = exp_q.pop_front();
      check_cnt++;
      if (dut_snap() !== exp_snap || player_x !== 9'd200)
         $display("[TB] FAIL hs_next_frame: got %h want %h", dut_snap(), exp_snap);
      else pass_cnt++;
      last_snap = exp_snap;
      check_cnt++;
      if (frame_cnt !== 16'(exp_frames)) $display("[TB] FAIL hs_frame_cnt: got %0d want %0d", frame_cnt, exp_frames);
      else pass_cnt++;
      upd_valid = 1'b0;
      end_frame();
   endtask

   task automatic test_stall();
      set_inputs(6);
      frame_edge();
      h_cnt = 10'd1;
      cyc(3);
      end_frame();
      exp_stall = exp_stall + 1;
      check_cnt++;
      if (dut_snap() !== last_snap) $display("[TB] FAIL stale_shadows: got %h want %h", dut_snap(), last_snap);
      else pass_cnt++;
      check_cnt++;
      if (frame_cnt !== 16'(exp_frames) || upd_ready !== 1'b0)
         $display("[TB] FAIL stale_frame: got cnt=%0d ready=%0b want cnt=%0d ready=0", frame_cnt, upd_ready, exp_frames);
      else pass_cnt++;
`ifdef FRAME_SYNC_STALL_CNT_EN
      check_cnt++;
      if (stall_cnt !== 8'(exp_stall)) $display("[TB] FAIL stall_inc: got %0d want %0d", stall_cnt, exp_stall);
      else pass_cnt++;
`endif
      upd_valid = 1'b1;
      exp_q.push_back(in_snap());
      frame_edge();
      h_cnt = 10'd1;
      cyc(2);
      exp_snap = exp_q.pop_front();
      check_cnt++;
      if (dut_snap() !== exp_snap) $display("[TB] FAIL stall_recover: got %h want %h", dut_snap(), exp_snap);
      else pass_cnt++;
      last_snap = exp_snap;
      exp_stall = 0;
`ifdef FRAME_SYNC_STALL_CNT_EN
      check_cnt++;
      if (stall_cnt !== 8'd0) $display("[TB] FAIL stall_clear: got %0d want 0", stall_cnt);
      else pass_cnt++;
`endif
      upd_valid = 1'b0;
      end_frame();
   endtask

   task automatic test_dark();
      dark_trig = 1'b1;
      cyc(1);
      dark_trig = 1'b0;
      check_cnt++;
      if (isDark !== 1'b1) $display("[TB] FAIL dark_on: got %0b want 1", isDark);
      else pass_cnt++;
      fast_frame();
      fast_frame();
      check_cnt++;
      if (isDark !== 1'b1) $display("[TB] FAIL dark_hold2: got %0b want 1", isDark);
      else pass_cnt++;
      frame_edge();
      check_cnt++;
      if (isDark !== 1'b1) $display("[TB] FAIL dark_at_fs3: got %0b want 1", isDark);
      else pass_cnt++;
      h_cnt = 10'd1;
      cyc(1);
      check_cnt++;
      if (isDark !== 1'b0) $display("[TB] FAIL dark_off3: got %0b want 0", isDark);
      else pass_cnt++;
      end_frame();
      if (exp_stall < 255) exp_stall = exp_stall + 1;
      // Retrigger after two frames restarts the full count
      dark_trig = 1'b1;
      cyc(1);
      dark_trig = 1'b0;
      fast_frame();
      fast_frame();
      dark_trig = 1'b1;
      cyc(1);
      dark_trig = 1'b0;
      fast_frame();
      fast_frame();
      check_cnt++;
      if (isDark !== 1'b1) $display("[TB] FAIL dark_retrig_hold: got %0b want 1", isDark);
      else pass_cnt++;
      fast_frame();
      check_cnt++;
      if (isDark !== 1'b0) $display("[TB] FAIL dark_retrig_off: got %0b want 0", isDark);
      else pass_cnt++;
      // Trigger on the same clock the timer sees its last frame_start
      dark_trig = 1'b1;
      cyc(1);
      dark_trig = 1'b0;
      fast_frame();
      fast_frame();
      frame_edge();
      dark_trig = 1'b1;
      cyc(1);
      dark_trig = 1'b0;
      check_cnt++;
      if (isDark !== 1'b1) $display("[TB] FAIL dark_coincident: got %0b want 1", isDark);
      else pass_cnt++;
      h_cnt = 10'd1;
      end_frame();
      if (exp_stall < 255) exp_stall = exp_stall + 1;
      fast_frame();
      fast_frame();
      check_cnt++;
      if (isDark !== 1'b1) $display("[TB] FAIL dark_reload_hold: got %0b want 1", isDark);
      else pass_cnt++;
      fast_frame();
      check_cnt++;
      if (isDark !== 1'b0) $display("[TB] FAIL dark_reload_off: got %0b want 0", isDark);
      else pass_cnt++;
   endtask

   task automatic test_cond_hold();
      int pulses;
      pulses = 0;
      v_cnt  = 10'd480;
      h_cnt  = 10'd0;
      for (int i = 0; i < 6; i++) begin
         if (i == 4) h_cnt = 10'd1;
         cyc(1);
         if (frame_start === 1'b1) pulses++;
      end
      model_frame();
      check_cnt++;
      if (pulses != 1) $display("[TB] FAIL cond_hold_pulses: got %0d want 1", pulses);
      else pass_cnt++;
      check_cnt++;
      if (frame_cnt !== 16'(exp_frames)) $display("[TB] FAIL cond_hold_cnt: got %0d want %0d", frame_cnt, exp_frames);
      else pass_cnt++;
      end_frame();
      if (exp_stall < 255) exp_stall = exp_stall + 1;
   endtask

   task automatic test_reset_mid_blank();
      dark_trig = 1'b1;
      cyc(1);
      dark_trig = 1'b0;
      frame_edge();
      h_cnt = 10'd1;
      cyc(1);
      check_cnt++;
      if (upd_ready !== 1'b1 || isDark !== 1'b1)
         $display("[TB] FAIL pre_reset_blank: got ready=%0b dark=%0b want 1 1", upd_ready, isDark);
      else pass_cnt++;
      #2 rst = 1'b0;
      #1;
      check_cnt++;
      if (all_outs() !== '0) $display("[TB] FAIL async_reset: got %h want 0", all_outs());
      else pass_cnt++;
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      set_inputs(9);
      upd_valid = 1'b1;
      exp_q.push_back(in_snap());
      end_frame();
      check_cnt++;
      if (upd_ready !== 1'b0 || dut_snap() !== '0)
         $display("[TB] FAIL post_reset_active: got ready=%0b snap=%h want 0", upd_ready, dut_snap());
      else pass_cnt++;
      frame_edge();
      h_cnt = 10'd1;
      cyc(2);
      exp_snap = exp_q.pop_front();
      check_cnt++;
      if (dut_snap() !== exp_snap || frame_cnt !== 16'(exp_frames))
         $display("[TB] FAIL post_reset_accept: got %h cnt=%0d want %h cnt=%0d", dut_snap(), frame_cnt, exp_snap, exp_frames);
      else pass_cnt++;
      last_snap = exp_snap;
      upd_valid = 1'b0;
      end_frame();
   endtask

   task automatic test_shift();
      rst = 1'b0;
      cyc(1);
      rst = 1'b1;
      model_reset();
      for (int f = 0; f < 8; f++) fast_frame();
      check_cnt++;
      if (shift !== 6'(exp_shift) || exp_shift != 2)
         $display("[TB] FAIL shift_8: got %0d want 2", shift);
      else pass_cnt++;
      for (int f = 8; f < 252; f++) fast_frame();
      check_cnt++;
      if (shift !== 6'd63) $display("[TB] FAIL shift_max: got %0d want 63", shift);
      else pass_cnt++;
      for (int f = 252; f < 255; f++) fast_frame();
      check_cnt++;
      if (shift !== 6'd63) $display("[TB] FAIL shift_no_early_wrap: got %0d want 63", shift);
      else pass_cnt++;
      fast_frame();
      check_cnt++;
      if (shift !== 6'(exp_shift) || frame_cnt !== 16'(exp_frames))
         $display("[TB] FAIL shift_wrap: got shift=%0d cnt=%0d want %0d %0d", shift, frame_cnt, exp_shift, exp_frames);
      else pass_cnt++;
`ifdef FRAME_SYNC_STALL_CNT_EN
      check_cnt++;
      if (stall_cnt !== 8'(exp_stall)) $display("[TB] FAIL stall_saturate: got %0d want %0d", stall_cnt, exp_stall);
      else pass_cnt++;
`endif
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst       = 1'b0;
      h_cnt     = '0;
      v_cnt     = '0;
      upd_valid = 1'b0;
      dark_trig = 1'b0;
      set_inputs(0);
      model_reset();
      test_reset();
      test_handshake();
      test_stall();
      test_dark();
      test_cond_hold();
      test_reset_mid_blank();
      test_shift();
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule

// File: doc/frame_sync_ctrl.md
Name: frame_sync_ctrl

Overview:
- Frame-level sequencer in front of the game display layer mux.
- Captures game-logic sprite and state values into shadow registers only during vertical blanking, so one rendered frame never mixes two game states.
- Generates the per-frame timing that drives the display: frame pulse, frame counter, interface scroll `shift`, and timed `isDark` flash.
- Sits between the game FSM/physics logic and the display path; all display-side inputs come from this block's shadow outputs.

Parameters:
- V_VISIBLE, 480, first blanking line; frame boundary when v_cnt reaches this value.
- SHIFT_DIV, 4, frames per `shift` increment.
- SHIFT_MAX, 63, last `shift` value before wrap to 0.
- DARK_FRAMES, 30, frames `isDark` stays high after a trigger.

Ports:
- clk  in  1  system clock (faster than or equal to pixel clock; h_cnt/v_cnt may hold for several cycles)
- rst  in  1  asynchronous, active-low reset
- h_cnt  in  10  horizontal pixel counter from VGA timing
- v_cnt  in  10  vertical line counter from VGA timing
- upd_valid  in  1  game logic offers a new state snapshot
- upd_ready  out  1  block accepts the snapshot this cycle
- in_state, in_player_state, in_boss_state  in  4 each  game/player/boss state
- in_player_x, in_player_y, in_boss_x, in_boss_y, in_obj_x, in_obj_y  in  9 each  positions
- in_key_find, in_life, in_todo  in  2 each  HUD values
- in_play_valid  in  4  active-player mask
- dark_trig  in  1  one-cycle request to start a dark flash
- state, player_state, boss_state, player_x … play_valid  out  same widths  shadowed copies of in_*
- frame_start  out  1  one-cycle pulse at each frame boundary
- frame_cnt  out  16  frames since reset, wraps
- shift  out  6  interface scroll offset
- isDark  out  1  dark-flash active

Behaviour:
- Reset (rst=0, async): all shadow outputs 0; upd_ready=0; frame_start=0; frame_cnt=0; shift=0; isDark=0; FSM = S_ACTIVE; divider counters 0.
- Boundary detect: cond = (v_cnt==V_VISIBLE && h_cnt==0). A registered copy gives the rising edge. frame_start is high exactly one clk on that edge (1-cycle latency from cond), even if cond holds for several clocks.
- FSM:
  - S_ACTIVE: upd_ready=0. On frame_start go to S_BLANK.
  - S_BLANK: upd_ready=1.
    - upd_valid&&upd_ready: latch all in_* into shadows on that edge, go to S_HOLD.
    - v_cnt<V_VISIBLE (new frame began) with no handshake: go to S_ACTIVE, shadows unchanged.
  - S_HOLD: upd_ready=0. On v_cnt<V_VISIBLE go to S_ACTIVE.
- At most one snapshot accepted per frame. upd_valid held by the producer is accepted on the first S_BLANK cycle (ready is not combinationally dependent on valid).
- frame_cnt: +1 on each frame_start, 16-bit wrap.
- shift: a divider counts frame_start 0..SHIFT_DIV-1. On terminal count, shift advances; shift==SHIFT_MAX wraps to 0.
- Dark timer:
  - dark_trig loads DARK_FRAMES and sets isDark=1 on the next clk.
  - Each frame_start decrements the timer; isDark clears when it reaches 0.
  - dark_trig during an active flash reloads (restart).
  - dark_trig coincident with frame_start: the reload wins.
- Reset mid-frame returns to S_ACTIVE; the first snapshot is accepted in the following blanking.

Optional Feature:
- Macro FRAME_SYNC_STALL_CNT_EN.
- Defined: adds output stall_cnt (8 bits, reset 0). It increments, saturating at 255, on each S_BLANK→S_ACTIVE transition without a handshake, i.e. frames rendered with stale state. It clears on the next accepted snapshot.
- Undefined: port and logic absent; the rest is unchanged.

Decomposition:
- Shared package `display_pkg`: V_VISIBLE, H_VISIBLE=640, V_TOTAL=525, FSM state encodings, shadow-field widths.
- One sub-module: `dark_timer` (trigger/reload/frame-decrement counter driving isDark).

Test Plan:
- Reset then frame boundary: hold upd_valid=1, in_player_x=100, run v_cnt to 480. frame_start pulses once, upd_ready rises next cycle, player_x=100 one clk after handshake, FSM in S_HOLD.
- In S_HOLD (same blanking), change in_player_x to 200 with upd_valid=1. upd_ready=0 and player_x stays 100 until next blanking, then becomes 200.
- No upd_valid for one frame: shadows unchanged, frame_cnt +1. With FRAME_SYNC_STALL_CNT_EN, stall_cnt=1; after the next accepted snapshot, stall_cnt=0.
- 8 frames with SHIFT_DIV=4: shift=2. Force shift=63 boundary: next terminal count gives shift=0.
- dark_trig pulse, DARK_FRAMES=3: isDark=1 next clk, cleared after 3rd frame_start. Retrigger after 2 frames: isDark stays high 3 more frames.
- Hold cond (v_cnt=480, h_cnt=0) for 4 clks: exactly one frame_start. Assert rst mid-S_BLANK: all outputs 0 immediately.
